dmem_burst_master: RTL

- Initiator side of the data-memory port: converts single- or multi-beat load/store requests from the core into cycle-by-cycle memory accesses.
- Drives address, write data, write enable and read enable.
- Captures combinational read data into a registered, back-pressurable output stream.
- Sits between the processor's load/store stage and the 8-word, 16-bit data memory.

---
 rtl/dmem_burst_master_if.sv | 48 ++++
 rtl/dmem_burst_master.sv | 110 +++++++++++
 2 files changed

// File: rtl/dmem_burst_master_if.sv
// Request, store-data, load-data and memory-side signals of the data-memory burst master.
// The master modport is the burst master's view; slave is the core/memory environment's view.
interface dmem_burst_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  mem_read_data,
        output req_ready, wr_ready, rd_valid, rd_data, busy, done,
        output mem_access_addr, mem_write_data, mem_write_en, mem_read
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wr_valid, wr_data,
        output rd_ready,
        output mem_read_data,
        input  req_ready, wr_ready, rd_valid, rd_data, busy, done,
        input  mem_access_addr, mem_write_data, mem_write_en, mem_read
    );
endinterface

// File: rtl/dmem_burst_master.sv
// Burst master: store beats strobe memory in the cycle they arrive; load beats appear on rd_data
// one cycle after issue (2 cycles after accept), and a held rd_data blocks further reads.
module dmem_burst_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 4,
    parameter int MAX_LEN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_burst_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              done_q;
    logic              busy_q;

    logic [LEN_W-1:0]  eff_len;
    logic              wr_fire;
    logic              rd_issue;
    logic              rd_pop;

    // Strobes are gated by rst_n so a reset cycle never touches memory or consumes a store beat.
    always_comb begin
        eff_len  = (bus.req_len > MAX_LEN_L) ? MAX_LEN_L : bus.req_len;
        wr_fire  = rst_n && (state == WRITE) && bus.wr_valid;
        rd_issue = rst_n && (state == READ) && (cnt != len_q) && (!rd_valid_q || bus.rd_ready);
        rd_pop   = rd_valid_q && bus.rd_ready;
    end

    assign bus.req_ready       = rst_n && (state == IDLE);
    assign bus.wr_ready        = rst_n && (state == WRITE);
    assign bus.mem_write_en    = wr_fire;
    assign bus.mem_write_data  = wr_fire ? bus.wr_data : '0;
    assign bus.mem_read        = rd_issue;
    assign bus.mem_access_addr = addr_q;
    assign bus.rd_valid        = rd_valid_q;
    assign bus.rd_data         = rd_data_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            cnt        <= '0;
            len_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q <= bus.req_addr;
                        cnt    <= '0;
                        len_q  <= eff_len;
                        busy_q <= 1'b1;
                        if (eff_len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= bus.req_write ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt    <= cnt + LEN_W'(1);
                        if ((cnt + LEN_W'(1)) == len_q) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // Issuing while popping keeps rd_valid high, giving one beat per cycle.
                    if (rd_issue) begin
                        rd_data_q  <= bus.mem_read_data;
                        rd_valid_q <= 1'b1;
                        addr_q     <= addr_q + ADDR_W'(1);
                        cnt        <= cnt + LEN_W'(1);
                    end else if (rd_pop) begin
                        rd_valid_q <= 1'b0;
                        if (cnt == len_q) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
